mem_arb: RTL and testbench

- Single-port arbiter between instruction fetch (IF) and load/store (LS) for the one unified, synchronous-read memory.
- Grants at most one access per cycle and tracks which requester owns each in-flight read.
- Returns read data to that owner with a fixed latency, and discards fetch data cancelled by a branch flush.
- Sits between the IF/MEM stages and the memory macro.

---
 rtl/mem_arb.sv | 115 +++++++++++
 tb/tb_mem_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: IF/LS arbiter for one synchronous-read memory, LS priority; data/store ack returns 2 cycles after grant.
// Returns cannot be stalled; a losing requester holds req. Optional IF anti-starvation via MEM_ARB_STARVE_GUARD_EN.
module mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic w_force_if;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_s1_if_live;
  logic w_unused_lsb;

  logic              r_s1_vld;
  logic              r_s1_ls;
  logic              r_s1_st;
  logic              r_if_vld;
  logic              r_ls_vld;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] r_starve_cnt;

  assign w_force_if = (r_starve_cnt == 3'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset || !if_req || w_if_gnt) begin
      r_starve_cnt <= 3'd0;
    end else if (!w_force_if) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end
`else
  logic w_unused_starve;

  assign w_force_if      = 1'b0;
  assign w_unused_starve = |3'(STARVE_MAX);
`endif

  assign w_ls_gnt = !reset && ls_req && !(if_req && w_force_if);
  assign w_if_gnt = !reset && if_req && (!ls_req || w_force_if);

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign mem_en    = w_if_gnt | w_ls_gnt;
  assign mem_we    = w_ls_gnt & ls_we;
  assign mem_wdata = (w_ls_gnt && ls_we) ? ls_wdata : '0;

  // Word-aligned: byte-offset bits are dropped, not trapped.
  always_comb begin
    mem_addr = '0;
    if (w_ls_gnt) begin
      mem_addr = {ls_addr[ADDR_W-1:2], 2'b00};
    end else if (w_if_gnt) begin
      mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
    end
  end
  assign w_unused_lsb = ^{if_addr[1:0], ls_addr[1:0]};

  // An IF entry in stage 1 survives only if no flush arrives while its data is on mem_rdata.
  assign w_s1_if_live = r_s1_vld && !r_s1_ls && !if_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_ls    <= 1'b0;
      r_s1_st    <= 1'b0;
      r_if_vld   <= 1'b0;
      r_ls_vld   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_s1_vld <= (w_if_gnt && !if_flush) || w_ls_gnt;
      r_s1_ls  <= w_ls_gnt;
      r_s1_st  <= w_ls_gnt & ls_we;
      r_if_vld <= w_s1_if_live;
      r_ls_vld <= r_s1_vld & r_s1_ls;
      if (w_s1_if_live) begin
        r_if_rdata <= mem_rdata;
      end
      if (r_s1_vld && r_s1_ls && !r_s1_st) begin
        r_ls_rdata <= mem_rdata;
      end
    end
  end

  assign if_valid = r_if_vld;
  assign ls_valid = r_ls_vld;
  assign if_rdata = r_if_rdata;
  assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: grant checks inline, read returns checked against a scoreboard of expected completions.
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_HIT = 5;
`else
  localparam int STARVE_HIT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_flush, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        st;
  } exp_t;

  exp_t        q_if[$];
  exp_t        q_ls[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_ls = '0;
  logic [31:0] mem [0:255];
  logic [31:0] mem_q;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model, preloaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem[4]   <= 32'hC800_0000;
      mem[5]   <= 32'h0BAD_F00D;
      mem[8]   <= 32'h1111_1111;
      mem[9]   <= 32'h2222_2222;
      mem[10]  <= 32'h3333_3333;
      mem[64]  <= 32'hDEAD_BEEF;
      mem[128] <= 32'h0000_0000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      mem_q <= mem[mem_addr[9:2]];
    end
  end
  assign mem_rdata = mem_q;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_if(input logic [31:0] dat);
    exp_t e;
    e.cyc = cyc + 2; e.dat = dat; e.st = 1'b0;
    q_if.push_back(e);
  endtask

  task automatic push_ls(input logic [31:0] dat, input logic st);
    exp_t e;
    e.cyc = cyc + 2; e.dat = dat; e.st = st;
    q_ls.push_back(e);
  endtask

  // End of cycle: compare completions against the scoreboard at negedge, then advance.
  task automatic tick();
    bit   e;
    exp_t d;
    @(negedge clk);
    e = (q_if.size() > 0) && (q_if[0].cyc == cyc);
    chk1("if_valid", if_valid, e);
    if (e) begin
      d = q_if.pop_front();
      chk32("if_rdata", if_rdata, d.dat);
    end
    e = (q_ls.size() > 0) && (q_ls[0].cyc == cyc);
    chk1("ls_valid", ls_valid, e);
    if (e) begin
      d = q_ls.pop_front();
      if (d.st) begin
        chk32("ls_rdata_held", ls_rdata, last_ls);
      end else begin
        chk32("ls_rdata", ls_rdata, d.dat);
        last_ls = d.dat;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; if_flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; if_flush = 1'b0;
    if_addr = 32'h10; ls_addr = 32'h100; ls_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    // Reset state: grants forced low despite both requests.
    #1;
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_ls_gnt", ls_gnt, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_ls_rdata", ls_rdata, 32'h0);
    tick();
    tick();
    reset = 1'b0; idle();
    tick();

    // Lone fetch.
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk1("lone_if_gnt", if_gnt, 1'b1);
    chk1("lone_ls_gnt", ls_gnt, 1'b0);
    chk1("lone_mem_en", mem_en, 1'b1);
    chk1("lone_mem_we", mem_we, 1'b0);
    chk32("lone_mem_addr", mem_addr, 32'h10);
    push_if(32'hC800_0000);
    tick();
    idle();
    tick(); tick(); tick();

    // Contention: LS first, IF next cycle.
    if_req = 1'b1; if_addr = 32'h14; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    #1;
    chk1("cont_ls_gnt", ls_gnt, 1'b1);
    chk1("cont_if_gnt0", if_gnt, 1'b0);
    chk32("cont_mem_addr0", mem_addr, 32'h100);
    push_ls(32'hDEAD_BEEF, 1'b0);
    tick();
    ls_req = 1'b0;
    #1;
    chk1("cont_if_gnt1", if_gnt, 1'b1);
    chk32("cont_mem_addr1", mem_addr, 32'h14);
    push_if(32'h0BAD_F00D);
    tick();
    idle();
    tick(); tick(); tick();

    // Starvation: continuous LS traffic, IF waiting from the first cycle.
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    for (int k = 1; k <= 8; k++) begin
      bit e;
      #1;
      e = (k == STARVE_HIT) && if_req;
      chk1("starve_if_gnt", if_gnt, e);
      chk1("starve_ls_gnt", ls_gnt, !e);
      if (e) push_if(32'hC800_0000);
      else   push_ls(32'hDEAD_BEEF, 1'b0);
      tick();
      if (e) if_req = 1'b0;
    end
    idle();
    tick(); tick(); tick();

    // Flush: fetches at 1 and 2 with flush at 2 are dropped; fetch at 3 completes.
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    chk1("fl_gnt1", if_gnt, 1'b1);
    tick();
    if_addr = 32'h24; if_flush = 1'b1;
    #1;
    chk1("fl_gnt2", if_gnt, 1'b1);
    tick();
    if_addr = 32'h28; if_flush = 1'b0;
    #1;
    chk1("fl_gnt3", if_gnt, 1'b1);
    push_if(32'h3333_3333);
    tick();
    idle();
    tick(); tick(); tick();

    // Flush on a fetch's completion cycle does not suppress it; flush alongside LS completion.
    if_req = 1'b1; if_addr = 32'h14;
    push_if(32'h0BAD_F00D);
    tick();
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    push_ls(32'hDEAD_BEEF, 1'b0);
    tick();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h10; if_flush = 1'b1;
    #1;
    chk1("fl2_if_gnt", if_gnt, 1'b1);
    tick();
    if_req = 1'b0; if_flush = 1'b1;
    tick();
    idle();
    tick(); tick(); tick();

    // Store with misaligned address, then load back.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h203; ls_wdata = 32'h1234_5678;
    #1;
    chk1("st_ls_gnt", ls_gnt, 1'b1);
    chk1("st_mem_we", mem_we, 1'b1);
    chk32("st_mem_addr", mem_addr, 32'h200);
    chk32("st_mem_wdata", mem_wdata, 32'h1234_5678);
    push_ls(32'h0, 1'b1);
    tick();
    ls_we = 1'b0; ls_addr = 32'h200;
    #1;
    chk1("ld_mem_we", mem_we, 1'b0);
    chk32("ld_mem_addr", mem_addr, 32'h200);
    push_ls(32'h1234_5678, 1'b0);
    tick();
    idle();
    tick(); tick(); tick();

    // Reset mid-operation drops the in-flight load.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    #1;
    chk1("rm_ls_gnt", ls_gnt, 1'b1);
    tick();
    ls_req = 1'b0; reset = 1'b1;
    last_ls = '0;
    tick();
    reset = 1'b0;
    #1;
    chk1("rm_if_valid", if_valid, 1'b0);
    chk1("rm_ls_valid", ls_valid, 1'b0);
    chk32("rm_if_rdata", if_rdata, 32'h0);
    chk32("rm_ls_rdata", ls_rdata, 32'h0);
    chk1("rm_if_gnt", if_gnt, 1'b0);
    chk1("rm_ls_gnt", ls_gnt, 1'b0);
    chk1("rm_mem_en", mem_en, 1'b0);
    chk1("rm_mem_we", mem_we, 1'b0);
    chk32("rm_mem_addr", mem_addr, 32'h0);
    chk32("rm_mem_wdata", mem_wdata, 32'h0);
    tick(); tick(); tick();

    chk32("sb_if_drained", 32'(q_if.size()), 32'h0);
    chk32("sb_ls_drained", 32'(q_ls.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
